// File: rtl/gticc_rxcnt_check.sv
// Receive-side counter-pattern checker: locks onto an incrementing word stream,
// counts word errors while locked, detects loss of lock and reports word deltas.
module gticc_rxcnt_check #(
  parameter int DWIDTH   = 32,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int ERRW     = 32
) (
  input  logic                  rxusrclk,
  input  logic                  reset,
  input  logic                  rxvalid,
  input  logic [DWIDTH-1:0]     rxdata,
  input  logic [DWIDTH/8-1:0]   rxcharisk,
  input  logic                  clear,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [ERRW-1:0]       err_cnt,
  output logic [ERRW-1:0]       word_cnt,
  output logic [DWIDTH-1:0]     diff
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_LOCKED} state_t;

  state_t            r_state;
  logic [DWIDTH-1:0] r_expected;
  logic [DWIDTH-1:0] r_prev;
  logic [GW-1:0]     r_good;
  logic [BW-1:0]     r_bad;

  logic              w_skip;
  logic              w_match;
  logic [DWIDTH-1:0] w_seed;
  logic [DWIDTH-1:0] w_next;

  assign w_skip  = |rxcharisk;
  assign w_match = (rxdata == r_expected);
  assign w_seed  = rxdata + DWIDTH'(1);
  assign w_next  = r_expected + DWIDTH'(1);

  always_ff @(posedge rxusrclk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_expected <= '0;
      r_prev     <= '0;
      r_good     <= '0;
      r_bad      <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      word_cnt   <= '0;
      diff       <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (rxvalid) begin
        diff   <= rxdata - r_prev;
        r_prev <= rxdata;
      end
      if (!rxvalid) begin
        r_state <= S_IDLE;
        locked  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_expected <= w_seed;
            r_good     <= '0;
            r_state    <= S_SEEK;
          end
          S_SEEK: begin
            if (!w_skip && !w_match) begin
              r_good     <= '0;
              r_expected <= w_seed;
            end else begin
              r_expected <= w_next;
              if (!w_skip) begin
                if (r_good == GW'(LOCK_CNT - 1)) begin
                  r_state <= S_LOCKED;
                  locked  <= 1'b1;
                  r_bad   <= '0;
                  r_good  <= '0;
                end else begin
                  r_good <= r_good + GW'(1);
                end
              end
            end
          end
          S_LOCKED: begin
            if (w_skip) begin
              r_expected <= w_next;
            end else begin
              if (!(&word_cnt)) word_cnt <= word_cnt + ERRW'(1);
              if (w_match) begin
                r_bad      <= '0;
                r_expected <= w_next;
              end else begin
                err_pulse <= 1'b1;
                if (!(&err_cnt)) err_cnt <= err_cnt + ERRW'(1);
                // Loss of lock re-seeds from the offending word; otherwise keep
                // free-running so an isolated corrupt word costs one error.
                if (r_bad == BW'(LOSS_CNT - 1)) begin
                  r_state    <= S_SEEK;
                  locked     <= 1'b0;
                  r_good     <= '0;
                  r_bad      <= '0;
                  r_expected <= w_seed;
                end else begin
                  r_bad      <= r_bad + BW'(1);
                  r_expected <= w_next;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
      // Later assignment overrides any same-cycle increment.
      if (clear) begin
        err_cnt  <= '0;
        word_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_gticc_rxcnt_check.sv
// Bench for gticc_rxcnt_check: vector table, directed corner sequences and a
// randomized stream checked against a behavioural model.
module tb_gticc_rxcnt_check;
  localparam int LOCK = 8;
  localparam int LOSS = 4;

  logic        clk = 1'b0;
  logic        rst, vld, clr;
  logic [31:0] din;
  logic [3:0]  kk;
  logic        locked, pulse, s_locked, s_pulse;
  logic [31:0] ecnt, wcnt, diff, s_diff;
  logic [3:0]  s_ecnt, s_wcnt;

  always #5 clk = ~clk;

  gticc_rxcnt_check #(.DWIDTH(32), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERRW(32)) dut (
    .rxusrclk(clk), .reset(rst), .rxvalid(vld), .rxdata(din), .rxcharisk(kk),
    .clear(clr), .locked(locked), .err_pulse(pulse), .err_cnt(ecnt),
    .word_cnt(wcnt), .diff(diff));

  gticc_rxcnt_check #(.DWIDTH(32), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERRW(4)) dut_s (
    .rxusrclk(clk), .reset(rst), .rxvalid(vld), .rxdata(din), .rxcharisk(kk),
    .clear(clr), .locked(s_locked), .err_pulse(s_pulse), .err_cnt(s_ecnt),
    .word_cnt(s_wcnt), .diff(s_diff));

  int checks = 0;
  int fails  = 0;

  // Behavioural model: lock is a run of LOCK good increments, loss a run of
  // LOSS misses; counters are kept unbounded and saturated only when compared.
  bit          m_active, m_locked, m_pulse;
  logic [31:0] m_exp, m_prev, m_diff;
  int          m_run, m_miss;
  longint      m_err, m_words;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model(input bit r, input bit v, input logic [31:0] d,
                       input logic [3:0] k, input bit c);
    if (r) begin
      m_active = 0; m_locked = 0; m_pulse = 0; m_exp = 0; m_prev = 0; m_diff = 0;
      m_run = 0; m_miss = 0; m_err = 0; m_words = 0;
      return;
    end
    m_pulse = 0;
    if (!v) begin
      m_active = 0;
      m_locked = 0;
    end else begin
      m_diff = d - m_prev;
      m_prev = d;
      if (!m_active) begin
        m_active = 1; m_run = 0; m_exp = d + 32'd1;
      end else if (k != 0) begin
        m_exp = m_exp + 32'd1;
      end else if (!m_locked) begin
        if (d == m_exp) begin
          m_run++;
          if (m_run == LOCK) begin m_locked = 1; m_miss = 0; end
        end else m_run = 0;
        m_exp = d + 32'd1;
      end else begin
        m_words++;
        if (d == m_exp) m_miss = 0;
        else begin
          m_pulse = 1; m_err++; m_miss++;
          if (m_miss == LOSS) begin m_locked = 0; m_run = 0; m_miss = 0; end
        end
        m_exp = m_locked ? m_exp + 32'd1 : d + 32'd1;
      end
    end
    if (c) begin m_err = 0; m_words = 0; end
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] d,
                      input logic [3:0] k, input bit c);
    rst = r; vld = v; din = d; kk = k; clr = c;
    @(posedge clk);
    #1;
    model(r, v, d, k, c);
    chk("locked", locked, m_locked);
    chk("err_pulse", pulse, m_pulse);
    chk("err_cnt", ecnt, sat(m_err, 32));
    chk("word_cnt", wcnt, sat(m_words, 32));
    chk("diff", diff, m_diff);
    chk("s_err_cnt", s_ecnt, sat(m_err, 4));
    chk("s_word_cnt", s_wcnt, sat(m_words, 4));
    chk("s_locked", s_locked, m_locked);
  endtask

  typedef struct {
    bit          r, v, c, chk;
    logic [31:0] d;
    logic [3:0]  k;
    bit          e_lock, e_pulse;
    logic [31:0] e_err, e_diff;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input logic [31:0] d, input bit c,
                     input bit e_lock, input bit e_pulse,
                     input logic [31:0] e_err, input logic [31:0] e_diff);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.k = 4'h0; t.c = c; t.chk = c ? 1'b0 : 1'b1;
    t.e_lock = e_lock; t.e_pulse = e_pulse; t.e_err = e_err; t.e_diff = e_diff;
    tbl.push_back(t);
  endtask

  task automatic fill(input logic [31:0] d);
    vec_t t;
    t.r = 0; t.v = 1; t.d = d; t.k = 4'h0; t.c = 0; t.chk = 0;
    t.e_lock = 0; t.e_pulse = 0; t.e_err = 0; t.e_diff = 0;
    tbl.push_back(t);
  endtask

  initial begin
    logic [31:0] nx, e0, w0, b;
    rst = 1; vld = 0; clr = 0; din = 0; kk = 0;

    // Lock on 0x100.., then a single corrupt word in place of 0x200.
    add(1, 0, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 8; i++)
      add(0, 1, 32'h100 + i, 0, i == 8, 0, 0, (i == 0) ? 32'h100 : 32'h1);
    for (int d = 32'h109; d <= 32'h1FF; d++) fill(d);
    add(0, 1, 32'hDEADBEEF, 0, 1, 1, 1, 32'hDEADBCF0);
    add(0, 1, 32'h201, 0, 1, 0, 1, 32'h21524312);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].c);
      if (tbl[i].chk) begin
        chk("tbl_locked", locked, tbl[i].e_lock);
        chk("tbl_pulse", pulse, tbl[i].e_pulse);
        chk("tbl_err", ecnt, tbl[i].e_err);
        chk("tbl_diff", diff, tbl[i].e_diff);
      end
    end

    // Jump by +0x10: four errors, lock drops, re-lock 8 matches after re-seed.
    nx = 32'h202;
    for (int i = 0; i < 14; i++) begin step(0, 1, nx, 0, 0); nx++; end
    nx += 32'h10;
    e0 = ecnt;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, nx, 0, 0); nx++;
      chk("jump_pulse", pulse, 1);
    end
    chk("jump_unlock", locked, 0);
    chk("jump_err", ecnt, e0 + 4);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, nx, 0, 0); nx++;
      chk("relock", locked, i == 7);
    end
    chk("seek_no_err", ecnt, e0 + 4);

    // Wrap through 0xFFFFFFFF -> 0, then a K word in place of a counter value.
    step(0, 0, 0, 0, 0);
    chk("vld_low_unlock", locked, 0);
    nx = 32'hFFFFFFF0;
    e0 = ecnt;
    for (int i = 0; i < 22; i++) begin step(0, 1, nx, 0, 0); nx++; end
    chk("wrap_locked", locked, 1);
    chk("wrap_err", ecnt, e0);
    step(0, 1, 32'hABCD0000, 4'h1, 0); nx++;
    chk("skip_pulse", pulse, 0);
    step(0, 1, nx, 0, 0); nx++;
    chk("after_skip_pulse", pulse, 0);
    chk("after_skip_err", ecnt, e0);

    // Clear in the same cycle as a mismatch.
    step(0, 1, nx ^ 32'h55, 0, 1); nx++;
    chk("clr_pulse", pulse, 1);
    chk("clr_err", ecnt, 0);
    step(0, 1, nx, 0, 0); nx++;
    step(0, 1, nx ^ 32'h55, 0, 0); nx++;
    chk("clr_next_err", ecnt, 1);

    // 20 isolated errors saturate the 4-bit counter at 15.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, nx, 0, 0); nx++;
      step(0, 1, nx ^ 32'h8000, 0, 0); nx++;
    end
    chk("sat_small", s_ecnt, 4'hF);
    chk("sat_big", ecnt, 21);
    chk("sat_locked", locked, 1);

    // Reset while locked clears everything.
    step(1, 1, nx, 0, 0); nx++;
    chk("rst_locked", locked, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_err", ecnt, 0);
    chk("rst_words", wcnt, 0);
    chk("rst_diff", diff, 0);

    // Drop rxvalid while locked: lock falls, counters hold.
    for (int i = 0; i < 9; i++) begin step(0, 1, nx, 0, 0); nx++; end
    step(0, 1, nx ^ 32'h1, 0, 0); nx++;
    e0 = ecnt; w0 = wcnt;
    chk("pre_drop_locked", locked, 1);
    step(0, 0, nx, 0, 0);
    chk("drop_locked", locked, 0);
    chk("drop_err_hold", ecnt, e0);
    chk("drop_words_hold", wcnt, w0);

    // Randomized stream against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      b = $urandom_range(1, 32'hFFFF);
      if (r == 13) nx = nx + $urandom;
      if (r < 3)       step(0, 0, nx, 0, 0);
      else if (r < 8)  step(0, 1, $urandom, 4'($urandom_range(1, 15)), 0);
      else if (r < 13) step(0, 1, nx ^ b, 0, 0);
      else if (r == 14) step(0, 1, nx, 0, 1);
      else if (r == 15) step(1, 1, nx, 0, 0);
      else             step(0, 1, nx, 0, 0);
      nx++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
